mux_pipe_stage: RTL and testbench
=================================

MUX_PIPE_STAGE -- requirements
Module: mux_pipe_stage

Interface
REQ-001 Parameter WIDTH SHALL be: default 32; data width of each input and of the output.
REQ-002 Parameter NUM_IN SHALL be: default 4; number of selectable inputs, legal range 2..16.
REQ-003 Parameter SEL_W SHALL be: default $clog2(NUM_IN); select width, derived, never overridden.
REQ-004 Port clk SHALL be: input, 1 bit; the block's only clock, all state on its rising edge.
REQ-005 Port rst_n SHALL be: input, 1 bit; reset, asynchronous, active-low.
REQ-006 Port in_data SHALL be: input, NUM_IN*WIDTH bits; flattened inputs, input k at bits [k*WIDTH +: WIDTH].
REQ-007 Port in_sel SHALL be: input, SEL_W bits; index of the input to forward.
REQ-008 Port in_valid SHALL be: input, 1 bit; upstream offers in_data/in_sel.
REQ-009 Port in_ready SHALL be: output, 1 bit; block can accept this cycle.
REQ-010 Port flush SHALL be: input, 1 bit; synchronous discard of all held entries (pipeline kill).
REQ-011 Port out_data SHALL be: output, WIDTH bits; selected word.
REQ-012 Port out_sel_err SHALL be: output, 1 bit; the held entry had in_sel >= NUM_IN.
REQ-013 Port out_valid SHALL be: output, 1 bit; out_data/out_sel_err are valid.
REQ-014 Port out_ready SHALL be: input, 1 bit; downstream accepts this cycle.

Function
REQ-015 An input transfer SHALL occur when in_valid && in_ready at a rising edge; an output transfer when out_valid && out_ready.
REQ-016 Selection SHALL be captured at input transfer: data = in_data[in_sel*WIDTH +: WIDTH]; latency input transfer to out_valid SHALL be exactly 1 cycle when empty.
REQ-017 For in_sel >= NUM_IN the captured data SHALL be all-zero and sel_err SHALL be 1; otherwise sel_err 0.
REQ-018 Storage SHALL be a 2-entry skid buffer: main entry drives outputs, skid entry holds a word accepted while main is stalled.
REQ-019 in_ready SHALL equal !skid_valid, registered-only, with no combinational path from out_ready.
REQ-020 States SHALL be EMPTY (none held), ONE (main only), FULL (main+skid); out_valid = (state != EMPTY).
REQ-021 EMPTY: input transfer -> ONE.
REQ-022 ONE: input without output -> FULL (new word into skid); output without input -> EMPTY; both -> ONE with main replaced; neither -> ONE.
REQ-023 FULL: in_ready = 0; output transfer -> ONE with skid moved to main; otherwise hold.
REQ-024 Output words SHALL leave in acceptance order; no word lost or duplicated.
REQ-025 out_data/out_sel_err SHALL stay stable while out_valid && !out_ready.
REQ-026 flush SHALL force EMPTY at the next edge, dropping held entries and any simultaneous input transfer; flush takes priority over all other events.
REQ-027 In EMPTY, out_data SHALL hold its last value (not required zero); benches check it only when out_valid.

Reset
REQ-028 While rst_n = 0: state EMPTY, out_valid 0, in_ready 1, out_data all-zero, out_sel_err 0, skid contents all-zero.
REQ-029 Reset assertion mid-transfer SHALL discard all entries immediately; first input transfer allowed on the first rising edge after rst_n deasserts.

Structure
REQ-030 The state encoding (EMPTY/ONE/FULL) and the max-NUM_IN constant SHALL live in the shared processor package.
REQ-031 The 2-entry storage and handshake logic SHALL be one sub-module, pipe_skid_buf, parametrised on payload width (WIDTH+1); mux_pipe_stage instantiates it after the select logic.
REQ-032 The select logic SHALL be purely combinational and parameter-generic (no per-NUM_IN hand-coded cases).

Verification
REQ-033 Reset: rst_n low with in_valid=1 -> out_valid 0, in_ready 1, out_data 0; after release, in_sel=2, input2=0xDEADBEEF -> next cycle out_data 0xDEADBEEF, out_valid 1.
REQ-034 Back-pressure: out_ready=0, push A=0x11, B=0x22 -> in_ready 0 after B; out_ready=1 -> A then B on consecutive cycles, in_ready 1 after A leaves.
REQ-035 Streaming: out_ready=1, in_valid=1 for 8 cycles, in_sel cycling 0..3 -> 8 outputs, 1-cycle latency, order preserved, in_ready never 0.
REQ-036 Illegal select: NUM_IN=3, in_sel=3, in_data words all 0xFFFFFFFF -> out_data 0x00000000, out_sel_err 1.
REQ-037 Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid 0, in_ready 1; neither held nor offered word ever appears.
REQ-038 Random: NUM_IN in {2,5,16}, random valid/ready/sel/flush 10k cycles -> scoreboard matches exactly, REQ-025 stability holds.

Source files
------------

// File: rtl/mux_pipe_stage_pkg.sv
// Shared definitions for the mux pipeline stage: buffer occupancy states and
// the largest supported input count.
package mux_pipe_stage_pkg;

  localparam int MAX_NUM_IN = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mux_pipe_stage_if.sv
// Handshake bundle for mux_pipe_stage: upstream offer/accept, flush and the
// downstream selected-word channel.
interface mux_pipe_stage_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_sel_err, out_valid
  );

endinterface

// File: rtl/mux_pipe_stage_skid_buf.sv
// Two-entry skid buffer: the main entry drives the outputs, the skid entry
// catches a word accepted while main is stalled. in_ready is purely registered.
module pipe_skid_buf
  import mux_pipe_stage_pkg::*;
#(
  parameter int PAYLOAD_W = 33
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  input  logic                 out_ready
);

  buf_state_e             state_q, state_d;
  logic [PAYLOAD_W-1:0]   main_q, main_d;
  logic [PAYLOAD_W-1:0]   skid_q, skid_d;
  logic                   in_xfer;
  logic                   out_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    in_xfer  = in_valid && (state_q != ST_FULL);
    out_xfer = out_ready && (state_q != ST_EMPTY);
    // Flush wins over everything, including an input offered in the same cycle.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_d  = in_payload;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_d  = in_payload;
            state_d = ST_FULL;
          end else if (in_xfer && out_xfer) begin
            main_d  = in_payload;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign in_ready    = (state_q != ST_FULL);
  assign out_valid   = (state_q != ST_EMPTY);
  assign out_payload = main_q;

endmodule

// File: rtl/mux_pipe_stage.sv
// Selects one of NUM_IN words by in_sel and registers it, with a select-error
// flag, through a two-entry skid buffer.
module mux_pipe_stage
  import mux_pipe_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic             clk,
  input logic             rst_n,
  mux_pipe_stage_if.slave bus
);

  logic [WIDTH-1:0] words [NUM_IN];
  logic [WIDTH-1:0] sel_data;
  logic             sel_err;
  logic [WIDTH:0]   skid_in;
  logic [WIDTH:0]   skid_out;

  genvar gi;
  generate
    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
      $error("mux_pipe_stage: NUM_IN must be in 2..%0d", MAX_NUM_IN);
    end
    for (gi = 0; gi < NUM_IN; gi++) begin : g_word
      assign words[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Unmatched select codes (>= NUM_IN) fall through to zero data with err set.
  always_comb begin
    sel_data = '0;
    sel_err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (bus.in_sel == SEL_W'(k)) begin
        sel_data = words[k];
        sel_err  = 1'b0;
      end
    end
  end

  assign skid_in = {sel_err, sel_data};

  pipe_skid_buf #(
    .PAYLOAD_W (WIDTH + 1)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (bus.flush),
    .in_payload  (skid_in),
    .in_valid    (bus.in_valid),
    .in_ready    (bus.in_ready),
    .out_payload (skid_out),
    .out_valid   (bus.out_valid),
    .out_ready   (bus.out_ready)
  );

  assign bus.out_sel_err = skid_out[WIDTH];
  assign bus.out_data    = skid_out[WIDTH-1:0];

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Bench for mux_pipe_stage: directed scenarios on NUM_IN=4/3 instances and a
// queue-model random run on NUM_IN=2/5/16 instances.
module tb_mux_pipe_stage;

  localparam int W           = 32;
  localparam int RAND_CYCLES = 10000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mux_pipe_stage_if #(.WIDTH(W), .NUM_IN(4)) b4 ();
  mux_pipe_stage #(.WIDTH(W), .NUM_IN(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  mux_pipe_stage_if #(.WIDTH(W), .NUM_IN(3)) b3 ();
  mux_pipe_stage #(.WIDTH(W), .NUM_IN(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  // Random-run instances are driven through these max-width arrays.
  logic [16*W-1:0] rin_data   [3];
  logic [3:0]      rin_sel    [3];
  logic            rin_valid  [3];
  logic            rflush     [3];
  logic            rout_ready [3];
  logic            rin_ready  [3];
  logic            rout_valid [3];
  logic            rout_err   [3];
  logic [W-1:0]    rout_data  [3];

  logic [W:0]      mq        [3][$];
  logic [W:0]      prev_out  [3];
  bit              prev_stall[3];

  function automatic int ni_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 5 : 16;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rand
      localparam int NI = (gi == 0) ? 2 : (gi == 1) ? 5 : 16;
      localparam int SW = $clog2(NI);
      mux_pipe_stage_if #(.WIDTH(W), .NUM_IN(NI)) rb ();
      mux_pipe_stage #(.WIDTH(W), .NUM_IN(NI)) u_dut (.clk(clk), .rst_n(rst_n), .bus(rb.slave));
      assign rb.in_data      = rin_data[gi][NI*W-1:0];
      assign rb.in_sel       = rin_sel[gi][SW-1:0];
      assign rb.in_valid     = rin_valid[gi];
      assign rb.flush        = rflush[gi];
      assign rb.out_ready    = rout_ready[gi];
      assign rin_ready[gi]   = rb.in_ready;
      assign rout_valid[gi]  = rb.out_valid;
      assign rout_err[gi]    = rb.out_sel_err;
      assign rout_data[gi]   = rb.out_data;
    end
  endgenerate

  task automatic set4(input int k, input logic [W-1:0] v);
    b4.in_data[k*W +: W] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd2;
    b4.out_ready = 1'b0;
    set4(2, 32'hDEADBEEF);
    repeat (2) @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", b4.out_valid); end
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", b4.in_ready); end
    checks++; if (b4.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", b4.out_data); end
    checks++; if (b4.out_sel_err !== 1'b0) begin errors++; $display("FAIL reset_sel_err: got %b expected 0", b4.out_sel_err); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL reset_first_valid: got %b expected 1", b4.out_valid); end
    checks++; if (b4.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_first_data: got %h expected deadbeef", b4.out_data); end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_drain: got out_valid %b expected 0", b4.out_valid); end
  endtask

  task automatic test_backpressure();
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd0;
    set4(0, 32'h11);
    @(negedge clk);
    checks++; if (b4.out_data !== 32'h11 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_A_held: got %h/%b expected 00000011/1", b4.out_data, b4.out_valid); end
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one: got %b expected 1", b4.in_ready); end
    set4(0, 32'h22);
    @(negedge clk);
    checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b expected 0", b4.in_ready); end
    checks++; if (b4.out_data !== 32'h11) begin errors++; $display("FAIL bp_A_stable: got %h expected 00000011", b4.out_data); end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b4.out_data !== 32'h22 || b4.out_valid !== 1'b1) begin errors++; $display("FAIL bp_B_next: got %h/%b expected 00000022/1", b4.out_data, b4.out_valid); end
    checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_A: got %b expected 1", b4.in_ready); end
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", b4.out_valid); end
  endtask

  task automatic test_streaming();
    logic [W-1:0] exp_q [$];
    logic [W-1:0] exp_w;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) set4(k, W'($urandom));
      b4.in_sel = 2'(i % 4);
      b4.in_valid = 1'b1;
      exp_q.push_back(b4.in_data[(i % 4)*W +: W]);
      @(negedge clk);
      exp_w = exp_q.pop_front();
      checks++; if (b4.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, b4.in_ready); end
      checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== exp_w) begin errors++; $display("FAIL stream_data[%0d]: got %h/%b expected %h/1", i, b4.out_data, b4.out_valid, exp_w); end
    end
    b4.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b expected 0", b4.out_valid); end
  endtask

  task automatic test_illegal_sel();
    b3.in_data = '1;
    b3.in_sel = 2'd3;
    b3.in_valid = 1'b1;
    b3.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 32'h0) begin errors++; $display("FAIL illegal_data: got %h/%b expected 00000000/1", b3.out_data, b3.out_valid); end
    checks++; if (b3.out_sel_err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b expected 1", b3.out_sel_err); end
    b3.in_sel = 2'd1;
    @(negedge clk);
    checks++; if (b3.out_data !== 32'hFFFFFFFF || b3.out_sel_err !== 1'b0) begin errors++; $display("FAIL legal_after_illegal: got %h/%b expected ffffffff/0", b3.out_data, b3.out_sel_err); end
    b3.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_drain: got %b expected 0", b3.out_valid); end
  endtask

  task automatic test_flush();
    logic [W-1:0] w_new;
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd3;
    set4(3, 32'hA0A0_0001);
    @(negedge clk);
    set4(3, 32'hA0A0_0002);
    @(negedge clk);
    checks++; if (b4.in_ready !== 1'b0) begin errors++; $display("FAIL flush_setup_full: got in_ready %b expected 0", b4.in_ready); end
    b4.flush = 1'b1;
    set4(3, 32'hA0A0_0003);
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL flush_full: got valid %b ready %b expected 0 1", b4.out_valid, b4.in_ready); end
    b4.flush = 1'b0;
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got out_valid %b data %h expected 0", i, b4.out_valid, b4.out_data); end
    end
    // Flush in ONE while an input would otherwise be accepted.
    b4.in_valid = 1'b1;
    @(negedge clk);
    b4.flush = 1'b1;
    set4(3, 32'hA0A0_0004);
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_drop: got out_valid %b data %h expected 0", b4.out_valid, b4.out_data); end
    b4.flush = 1'b0;
    w_new = W'($urandom);
    set4(3, w_new);
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== w_new) begin errors++; $display("FAIL flush_recover: got %h/%b expected %h/1", b4.out_data, b4.out_valid, w_new); end
    b4.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL flush_recover_drain: got %b expected 0", b4.out_valid); end
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) begin
      mq[d].delete();
      prev_stall[d] = 1'b0;
    end
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int         ni;
        int         sw;
        int         s;
        logic [W:0] exp_w;
        bit         in_x;
        bit         out_x;
        ni = ni_of(d);
        sw = $clog2(ni);
        checks++; if (rout_valid[d] !== (mq[d].size() != 0)) begin errors++; $display("FAIL rand_n%0d_valid cyc %0d: got %b expected %b", ni, cyc, rout_valid[d], mq[d].size() != 0); end
        checks++; if (rin_ready[d] !== (mq[d].size() < 2)) begin errors++; $display("FAIL rand_n%0d_ready cyc %0d: got %b expected %b", ni, cyc, rin_ready[d], mq[d].size() < 2); end
        if (mq[d].size() != 0) begin
          checks++; if ({rout_err[d], rout_data[d]} !== mq[d][0]) begin errors++; $display("FAIL rand_n%0d_data cyc %0d: got %h expected %h", ni, cyc, {rout_err[d], rout_data[d]}, mq[d][0]); end
        end
        if (prev_stall[d]) begin
          checks++; if ({rout_err[d], rout_data[d]} !== prev_out[d]) begin errors++; $display("FAIL rand_n%0d_stable cyc %0d: got %h expected %h", ni, cyc, {rout_err[d], rout_data[d]}, prev_out[d]); end
        end
        for (int k = 0; k < 16; k++)
          rin_data[d][k*W +: W] = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
        rin_sel[d]    = 4'($urandom_range(0, (1 << sw) - 1));
        rin_valid[d]  = ($urandom_range(0, 99) < 70);
        rout_ready[d] = ($urandom_range(0, 99) < 60);
        rflush[d]     = ($urandom_range(0, 99) < 3);
        s = int'(rin_sel[d]);
        exp_w = (s >= ni) ? {1'b1, {W{1'b0}}} : {1'b0, rin_data[d][s*W +: W]};
        in_x  = rin_valid[d] && (mq[d].size() < 2);
        out_x = (mq[d].size() != 0) && rout_ready[d];
        prev_stall[d] = (mq[d].size() != 0) && !rout_ready[d] && !rflush[d];
        prev_out[d]   = {rout_err[d], rout_data[d]};
        if (rflush[d]) begin
          mq[d].delete();
        end else begin
          if (out_x) void'(mq[d].pop_front());
          if (in_x) mq[d].push_back(exp_w);
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      rin_valid[d] = 1'b0;
      rflush[d] = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] v;
    b4.out_ready = 1'b0;
    b4.in_valid = 1'b1;
    b4.in_sel = 2'd1;
    set4(1, 32'h5555_0001);
    @(negedge clk);
    set4(1, 32'h5555_0002);
    @(negedge clk);
    v = W'($urandom);
    set4(1, v);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (b4.out_valid !== 1'b0 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_flags: got valid %b ready %b expected 0 1", b4.out_valid, b4.in_ready); end
    checks++; if (b4.out_data !== 32'h0 || b4.out_sel_err !== 1'b0) begin errors++; $display("FAIL midreset_data: got %h/%b expected 00000000/0", b4.out_data, b4.out_sel_err); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b1 || b4.out_data !== v) begin errors++; $display("FAIL midreset_first: got %h/%b expected %h/1", b4.out_data, b4.out_valid, v); end
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_drain: got %b data %h expected 0", b4.out_valid, b4.out_data); end
  endtask

  initial begin
    rst_n = 1'b0;
    b4.in_data = '0; b4.in_sel = '0; b4.in_valid = 1'b0; b4.flush = 1'b0; b4.out_ready = 1'b0;
    b3.in_data = '0; b3.in_sel = '0; b3.in_valid = 1'b0; b3.flush = 1'b0; b3.out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      rin_data[d] = '0; rin_sel[d] = '0; rin_valid[d] = 1'b0;
      rflush[d] = 1'b0; rout_ready[d] = 1'b0;
    end
    test_reset();
    test_backpressure();
    test_streaming();
    test_illegal_sel();
    test_flush();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
